// File: rtl/intr_arbiter_pkg.sv
// rtl/intr_arbiter_pkg.sv - shared types and ID/index helpers for the interrupt arbiter
package intr_arbiter_pkg;

    typedef enum logic [1:0] {
        GwIdle      = 2'd0,
        GwPending   = 2'd1,
        GwInService = 2'd2
    } gw_state_e;

    // Source index i is reported to software as ID i+1; ID 0 is reserved for "none".
    function automatic int unsigned idx_to_id(int unsigned idx);
        return idx + 1;
    endfunction

    function automatic int unsigned id_to_idx(int unsigned id);
        return id - 1;
    endfunction

endpackage

// File: rtl/intr_arbiter_if.sv
// rtl/intr_arbiter_if.sv - claim/complete/irq bus between the arbiter and the core
interface intr_arbiter_if #(
    parameter int IdWidth = 4
);
    logic               claim_req_i;
    logic               claim_valid_o;
    logic [IdWidth-1:0] claim_id_o;
    logic               complete_req_i;
    logic [IdWidth-1:0] complete_id_i;
    logic               irq_o;
    logic [IdWidth-1:0] irq_id_o;

    modport master (
        output claim_req_i, complete_req_i, complete_id_i,
        input  claim_valid_o, claim_id_o, irq_o, irq_id_o
    );

    modport slave (
        input  claim_req_i, complete_req_i, complete_id_i,
        output claim_valid_o, claim_id_o, irq_o, irq_id_o
    );
endinterface

// File: rtl/intr_gateway.sv
// rtl/intr_gateway.sv - per-source IDLE/PENDING/IN_SERVICE gateway
module intr_gateway
    import intr_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic line,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic in_service
);

    gw_state_e state;

    // Pending is sticky and the line is ignored while in service.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= GwIdle;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            case (state)
                GwIdle: begin
                    if (line) begin
                        state   <= GwPending;
                        pending <= 1'b1;
                    end
                end
                GwPending: begin
                    if (claim_hit) begin
                        state      <= GwInService;
                        pending    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                GwInService: begin
                    if (complete_hit) begin
                        state      <= GwIdle;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= GwIdle;
                    pending    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// rtl/intr_arbiter.sv - PLIC-style interrupt target arbiter with threshold and claim/complete
module intr_arbiter
    import intr_arbiter_pkg::*;
#(
    parameter int NumSrc    = 8,
    parameter int PrioWidth = 3,
    parameter int IdWidth   = $clog2(NumSrc + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumSrc-1:0]           intr_src_i,
    input  logic [NumSrc*PrioWidth-1:0] prio_i,
    input  logic [PrioWidth-1:0]        threshold_i,
    output logic [NumSrc-1:0]           pending_o,
    output logic [NumSrc-1:0]           in_service_o,
    intr_arbiter_if.slave               bus
);

    logic [IdWidth-1:0]   win_id;
    logic [PrioWidth-1:0] win_prio;
    logic                 found;
    logic [NumSrc-1:0]    claim_hit;
    logic [NumSrc-1:0]    complete_hit;

    // Strict greater-than keeps the lowest index on a priority tie.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        found    = 1'b0;
        for (int i = 0; i < NumSrc; i++) begin
            if (pending_o[i] && (prio_i[i*PrioWidth +: PrioWidth] > threshold_i) &&
                (!found || (prio_i[i*PrioWidth +: PrioWidth] > win_prio))) begin
                found    = 1'b1;
                win_prio = prio_i[i*PrioWidth +: PrioWidth];
                win_id   = IdWidth'(idx_to_id(i));
            end
        end
    end

    for (genvar g = 0; g < NumSrc; g++) begin : g_src
        // IDs 0 and > NumSrc match no source, so they fall through harmlessly.
        assign claim_hit[g]    = bus.claim_req_i && (win_id == IdWidth'(idx_to_id(g)));
        assign complete_hit[g] = bus.complete_req_i &&
                                 (bus.complete_id_i == IdWidth'(idx_to_id(g)));

        intr_gateway u_gw (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .line         (intr_src_i[g]),
            .claim_hit    (claim_hit[g]),
            .complete_hit (complete_hit[g]),
            .pending      (pending_o[g]),
            .in_service   (in_service_o[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.irq_o         <= 1'b0;
            bus.irq_id_o      <= '0;
            bus.claim_valid_o <= 1'b0;
            bus.claim_id_o    <= '0;
        end else begin
            bus.irq_o         <= found;
            bus.irq_id_o      <= win_id;
            bus.claim_valid_o <= bus.claim_req_i;
            if (bus.claim_req_i) begin
                bus.claim_id_o <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// tb/tb_intr_arbiter.sv - scoreboard bench for intr_arbiter
module tb_intr_arbiter;
    localparam int NumSrc    = 8;
    localparam int PrioWidth = 3;
    localparam int IdWidth   = 4;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [NumSrc-1:0]           intr_src_i;
    logic [NumSrc*PrioWidth-1:0] prio_i;
    logic [PrioWidth-1:0]        threshold_i;
    logic [NumSrc-1:0]           pending_o;
    logic [NumSrc-1:0]           in_service_o;

    intr_arbiter_if #(.IdWidth(IdWidth)) bus ();

    intr_arbiter #(.NumSrc(NumSrc), .PrioWidth(PrioWidth)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .intr_src_i   (intr_src_i),
        .prio_i       (prio_i),
        .threshold_i  (threshold_i),
        .pending_o    (pending_o),
        .in_service_o (in_service_o),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int exp_claim_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Claim responses are checked here, independent of the stimulus thread.
    always @(negedge clk_i) begin
        if (!rst_i && bus.claim_valid_o) begin
            if (exp_claim_q.size() == 0) begin
                chk("claim_unexpected", 32'(bus.claim_id_o), 32'hFFFF_FFFF);
            end else begin
                chk("claim_id", 32'(bus.claim_id_o), 32'(exp_claim_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_prio(input int idx, input int val);
        prio_i[idx*PrioWidth +: PrioWidth] = PrioWidth'(val);
    endtask

    task automatic claim(input int exp_id);
        bus.claim_req_i = 1'b1;
        exp_claim_q.push_back(exp_id);
        tick();
        bus.claim_req_i = 1'b0;
    endtask

    task automatic complete(input int id);
        bus.complete_req_i = 1'b1;
        bus.complete_id_i  = IdWidth'(id);
        tick();
        bus.complete_req_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irq"},        32'(bus.irq_o),         0);
        chk({tag, "_irq_id"},     32'(bus.irq_id_o),      0);
        chk({tag, "_claim_v"},    32'(bus.claim_valid_o), 0);
        chk({tag, "_claim_id"},   32'(bus.claim_id_o),    0);
        chk({tag, "_pending"},    32'(pending_o),         0);
        chk({tag, "_in_service"}, 32'(in_service_o),      0);
    endtask

    initial begin
        rst_i              = 1'b1;
        intr_src_i         = '0;
        prio_i             = '0;
        threshold_i        = '0;
        bus.claim_req_i    = 1'b0;
        bus.complete_req_i = 1'b0;
        bus.complete_id_i  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Basic flow on source 3 (ID 4)
        set_prio(3, 5);
        intr_src_i[3] = 1'b1;
        tick();
        chk("basic_pend", 32'(pending_o), 32'h08);
        chk("basic_irq_early", 32'(bus.irq_o), 0);
        tick();
        chk("basic_irq", 32'(bus.irq_o), 1);
        chk("basic_irq_id", 32'(bus.irq_id_o), 4);
        intr_src_i[3] = 1'b0;
        claim(4);
        chk("basic_ins", 32'(in_service_o), 32'h08);
        chk("basic_pend_clr", 32'(pending_o), 0);
        tick();
        chk("basic_irq_drop", 32'(bus.irq_o), 0);
        chk("basic_claim_pulse", 32'(bus.claim_valid_o), 0);
        complete(4);
        chk("basic_done", 32'(in_service_o), 0);

        // Priority and tie-break: sources 1,5,6 with prio 3,6,6
        set_prio(1, 3);
        set_prio(5, 6);
        set_prio(6, 6);
        intr_src_i = 8'h62;
        tick();
        intr_src_i = '0;
        tick();
        chk("prio_pend", 32'(pending_o), 32'h62);
        chk("prio_irq_id", 32'(bus.irq_id_o), 6);
        bus.claim_req_i = 1'b1;
        exp_claim_q.push_back(6);
        tick();
        exp_claim_q.push_back(7);
        tick();
        exp_claim_q.push_back(2);
        tick();
        bus.claim_req_i = 1'b0;
        chk("prio_ins", 32'(in_service_o), 32'h62);
        chk("prio_pend_clr", 32'(pending_o), 0);
        complete(6);
        complete(7);
        complete(2);
        chk("prio_done", 32'(in_service_o), 0);

        // Threshold masks a prio equal to it
        set_prio(0, 2);
        threshold_i = 3'd2;
        intr_src_i[0] = 1'b1;
        tick();
        intr_src_i[0] = 1'b0;
        tick();
        chk("thr_pend", 32'(pending_o), 32'h01);
        chk("thr_irq_masked", 32'(bus.irq_o), 0);
        claim(0);
        chk("thr_pend_kept", 32'(pending_o), 32'h01);
        chk("thr_no_ins", 32'(in_service_o), 0);
        threshold_i = 3'd1;
        tick();
        chk("thr_irq", 32'(bus.irq_o), 1);
        chk("thr_irq_id", 32'(bus.irq_id_o), 1);

        // Invalid completes leave state alone
        complete(0);
        complete(9);
        complete(1);
        chk("inv_pend", 32'(pending_o), 32'h01);
        chk("inv_ins", 32'(in_service_o), 0);
        claim(1);
        chk("inv_claimed", 32'(in_service_o), 32'h01);

        // Simultaneous claim and complete
        set_prio(2, 4);
        intr_src_i[2] = 1'b1;
        tick();
        intr_src_i[2] = 1'b0;
        tick();
        intr_src_i[0] = 1'b1;
        bus.claim_req_i    = 1'b1;
        bus.complete_req_i = 1'b1;
        bus.complete_id_i  = IdWidth'(1);
        exp_claim_q.push_back(3);
        tick();
        bus.complete_req_i = 1'b0;
        chk("sim_ins", 32'(in_service_o), 32'h04);
        chk("sim_idle_gap", 32'(pending_o), 0);
        exp_claim_q.push_back(0);
        tick();
        bus.claim_req_i = 1'b0;
        chk("sim_repend", 32'(pending_o), 32'h01);
        chk("sim_ins2", 32'(in_service_o), 32'h04);
        intr_src_i[0] = 1'b0;
        complete(3);
        chk("sim_done", 32'(in_service_o), 0);

        // Re-pend with line held through complete
        set_prio(4, 7);
        intr_src_i[4] = 1'b1;
        tick();
        tick();
        chk("rep_irq_id", 32'(bus.irq_id_o), 5);
        claim(5);
        chk("rep_ins", 32'(in_service_o), 32'h10);
        chk("rep_pend", 32'(pending_o), 32'h01);
        complete(5);
        chk("rep_idle_pend", 32'(pending_o), 32'h01);
        chk("rep_idle_ins", 32'(in_service_o), 0);
        tick();
        chk("rep_repend", 32'(pending_o), 32'h11);
        chk("rep_irq_id_old", 32'(bus.irq_id_o), 1);
        tick();
        chk("rep_irq", 32'(bus.irq_o), 1);
        chk("rep_irq_id_new", 32'(bus.irq_id_o), 5);

        // Reset mid-operation with source 2 in service
        intr_src_i[4] = 1'b0;
        set_prio(4, 0);
        intr_src_i[2] = 1'b1;
        tick();
        intr_src_i[2] = 1'b0;
        tick();
        chk("rst_pre_pend", 32'(pending_o), 32'h15);
        claim(3);
        chk("rst_pre_ins", 32'(in_service_o), 32'h04);
        tick();
        rst_i = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst_i = 1'b0;
        tick();
        chk_all_zero("rst_after");

        chk("sb_empty", 32'(exp_claim_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
- Interrupt target arbiter that collects the `intr_o` vectors from the peripherals' interrupt handlers and presents one prioritised interrupt to a core.
- Each source has a per-source gateway with the states IDLE, PENDING and IN_SERVICE.
- A global threshold masks low-priority sources.
- Software takes ownership of a source with a claim handshake and releases it with a complete handshake, in PLIC style.
- It sits between the peripheral interrupt lines and the core's external interrupt input.

Parameters:
- `NumSrc`, default 8: number of interrupt sources. Source i (0-based) has ID i+1; ID 0 means "none".
- `PrioWidth`, default 3: width of each priority field. Priority 0 means never interrupt.
- `IdWidth`, default `$clog2(NumSrc+1)`: width of the ID fields. Derived; do not override.

Ports:
- `clk_i`  in  1  the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `intr_src_i`  in  NumSrc  level interrupt lines, one per source.
- `prio_i`  in  NumSrc*PrioWidth  per-source priority. Source i occupies bits [i*PrioWidth +: PrioWidth].
- `threshold_i`  in  PrioWidth  a source is eligible only when prio > threshold.
- `claim_req_i`  in  1  single-cycle claim request.
- `claim_valid_o`  out  1  one-cycle pulse; `claim_id_o` is valid while it is high.
- `claim_id_o`  out  IdWidth  ID of the claimed source, or 0 if nothing was eligible.
- `complete_req_i`  in  1  single-cycle completion request.
- `complete_id_i`  in  IdWidth  ID of the source being completed.
- `irq_o`  out  1  registered; high when any eligible source is pending.
- `irq_id_o`  out  IdWidth  registered ID of the current best candidate, or 0.
- `pending_o`  out  NumSrc  per-source PENDING state.
- `in_service_o`  out  NumSrc  per-source IN_SERVICE state.

Behaviour:
- Reset (asynchronous, while `rst_i`=1):
  - all gateways go to IDLE;
  - `irq_o`, `irq_id_o`, `claim_valid_o`, `claim_id_o`, `pending_o` and `in_service_o` are all 0.
- Gateway FSM, per source, on each clock edge:
  - IDLE -> PENDING when `intr_src_i[i]`=1.
  - PENDING -> IN_SERVICE when the source wins a claim. PENDING is sticky: a falling line does not clear it.
  - IN_SERVICE -> IDLE when `complete_req_i`=1 and `complete_id_i`=i+1. The line is ignored while IN_SERVICE.
  - After IN_SERVICE -> IDLE, a still-high line re-pends on the next edge, giving one IDLE cycle.
- Winner selection (combinational, from registered gateway state):
  - candidates are PENDING sources with prio > `threshold_i`;
  - the highest prio wins; a tie goes to the lowest index;
  - winner ID is 0 if there are no candidates.
- Outputs:
  - `irq_o` <= (winner ID != 0) and `irq_id_o` <= winner ID, both registered every cycle.
  - Latency: line rises before edge n -> PENDING after edge n -> `irq_o`=1 after edge n+1.
- Claim:
  - `claim_req_i`=1 at edge n makes `claim_valid_o`=1 and `claim_id_o`=winner ID for the cycle after edge n.
  - The winner moves to IN_SERVICE at the same edge.
  - `claim_valid_o` is 0 in all other cycles; `claim_id_o` holds its last value.
  - A claim with no candidate returns ID 0 and changes no state.
- Complete:
  - An ID of 0, greater than NumSrc, or naming a source not IN_SERVICE is ignored silently.
- Simultaneous claim and complete in one cycle:
  - both take effect;
  - the claim uses the pre-edge state, so a source being completed cannot be claimed in the same cycle.
- Same-cycle rise and claim: a line that rises in the cycle of a claim is not a candidate for that claim.
- Changes to threshold or priority take effect on the next `irq_o` update and never alter gateway state.
- Reset mid-operation: all IN_SERVICE sources are dropped to IDLE, with no pending completion obligation.

Decomposition:
- Package `intr_arbiter_pkg` holds:
  - the `gw_state_e` enum {GwIdle, GwPending, GwInService} with a 2-bit encoding;
  - a function for ID<->index conversion.
- Sub-module `intr_gateway`: one instance per source.
  - Inputs: `clk_i`, `rst_i`, line, `claim_hit`, `complete_hit`.
  - Outputs: pending, in_service.
- The top level owns winner selection (priority compare tree), the claim/complete decode and the output registers.

Test Plan:
- Reset then idle: `rst_i` pulsed mid-run with source 2 IN_SERVICE -> after release, all outputs 0 and `in_service_o`=0.
- Basic flow: NumSrc=8, prio[3]=5, threshold=0, raise `intr_src_i[3]` -> `irq_o`=1 with `irq_id_o`=4 two edges later; claim -> `claim_id_o`=4, `claim_valid_o` one cycle, `in_service_o[3]`=1, `irq_o`=0; complete ID 4 with line low -> IDLE.
- Priority and tie: sources 1, 5 and 6 pending with prio 3, 6, 6 -> claim returns 6. The next claim returns 7. The next returns 2.
- Threshold: prio[0]=2 with threshold=2 -> `irq_o` stays 0 and a claim returns 0. Setting threshold=1 -> `irq_o`=1 with ID 1.
- Invalid and simultaneous: complete ID 0, ID 9, and the ID of a PENDING source -> no state change. Claim plus complete on the same cycle -> both applied; the completed source is not re-claimed that cycle.
- Re-pend: a line held high through complete -> exactly one IDLE cycle, then PENDING again, then `irq_o` reasserts.
